instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Write-side counterpart of the processor's instruction decode path. It takes
//  field-level instruction requests (Op, Funct, Rn, Rd, Src2/Imm24) from the
//  calculator front end and packs them into 32-bit ARM words (cond = AL).
//  It then writes them sequentially into instruction memory.
//  When the program ends, or memory fills, it appends a halt word (branch-to-self)
//  so the core never fetches past the program.
// PARAMETERS
//  ADDR_W     6      word-address width of instruction memory; DEPTH = 2**ADDR_W
//  BASE_ADDR  0      first word address written after start
// PORTS
//  clk          in   1       system clock; all logic is rising-edge
//  reset        in   1       synchronous, active-high
//  start        in   1       pulse: rewind pointer to BASE_ADDR, clear flags, go IDLE
//  req_valid    in   1       request present
//  req_ready    out  1       encoder can accept a request this cycle
//  req_op       in   2       Op: 00 DP, 01 LDR/STR, 10 B; 11 illegal
//  req_funct    in   6       Funct -> Instr[25:20]
//  req_rn       in   4       Rn -> Instr[19:16]
//  req_rd       in   4       Rd -> Instr[15:12]
//  req_src2     in   12      Src2 -> Instr[11:0] (Op 00/01)
//  req_imm24    in   24      branch offset -> Instr[23:0] (Op 10)
//  req_last     in   1       with valid: this is the final instruction; halt follows
//  imem_we      out  1       instruction-memory write strobe (one cycle per word)
//  imem_addr    out  ADDR_W  word address
//  imem_wdata   out  32      encoded word
//  done         out  1       program plus halt written; held until start/reset
//  overflow     out  1       sticky: memory filled before req_last
//  err_illegal  out  1       sticky: an illegal request was dropped
// BEHAVIOUR
//  - Reset: req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0,
//    done=0, overflow=0, err_illegal=0, and the state is IDLE_WAIT.
//  - Encoding, combinational from the registered request:
//    - Op 00/01: {4'hE, op, funct, rn, rd, src2}.
//    - Op 10: {4'hE, 2'b10, funct[5:4], imm24}; rn, rd and src2 are ignored.
//  - Illegal requests: Op=11, or Op=10 with funct[5:4]!=2'b10.
//    - The request is consumed (handshake completes) but no word is written,
//      and err_illegal is set.
//    - If req_last is set, the halt word is still written.
//  - Handshake: transfer occurs when req_valid & req_ready on a rising edge.
//    - req_ready=1 only in IDLE.
//    - Requests are held registered; the input fields need to be stable only
//      in the transfer cycle.
//  - FSM:
//    - IDLE_WAIT: after reset, ready=0; start moves to IDLE.
//    - IDLE: ready=1; a transfer moves to WRITE, or to HALT if illegal & last.
//      An illegal transfer without last stays in IDLE.
//    - WRITE: imem_we=1 for exactly one cycle with the addr/wdata of the
//      request. Then ptr+1.
//      - If last, go to HALT.
//      - Else, if the new ptr == DEPTH-1, set overflow and go to HALT.
//      - Else go to IDLE.
//    - HALT: imem_we=1, wdata=32'hEAFFFFFE (B to self), then go to DONE.
//    - DONE: done=1, ready=0; start moves to IDLE.
//  - Latency: transfer at edge N -> imem_we high during cycle N+1. Throughput is
//    one instruction per 2 cycles.
//  - The last slot (DEPTH-1) is reserved for halt. The halt is always written,
//    and a normal word never wraps to BASE_ADDR.
//  - start takes priority in every state and aborts any in-flight write
//    (no imem_we that cycle).
//  - reset overrides start.
//  - Flags clear only on start or reset.
// STRUCTURE
//  - Shared package/header constants:
//    - OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10
//    - COND_AL=4'hE
//    - HALT_WORD=32'hEAFFFFFE
//    - FSM state encodings
//  - Sub-module instr_pack: combinational field packer plus legality check
//    (op, funct, rn, rd, src2, imm24 -> word, illegal). It is reusable by the
//    bench as the golden model.
// TESTING
//  - ADD R1,R2,#5 (op=00, funct=101000, rn=2, rd=1, src2=005), last=0
//    -> one write of 32'hE2821005 at addr 0; then ready=1.
//  - LDR R3,[R0,#8] (op=01, funct=011001, rn=0, rd=3, src2=008) with last=1
//    -> writes E5903008 @0, then EAFFFFFE @1; then done=1.
//  - B +3 (op=10, funct=100000, imm24=000003); then op=11 with last=1
//    -> EA000003 @0, err_illegal=1, EAFFFFFE @1, done=1.
//  - ADDR_W=2: 5 back-to-back legal requests, none last
//    -> writes @0..2, overflow=1, halt @3, done, ready=0.
//    The 4th and 5th requests are never accepted.
//  - start asserted in the WRITE cycle -> no imem_we, ptr=BASE_ADDR, flags=0,
//    ready=1 next cycle.
//  - reset mid-HALT -> all outputs at reset values; ready stays 0 until start.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instr_encoder_pkg
// Brief  : Shared constants, FSM state type and legality helper for the
//          instruction encoder.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package instr_encoder_pkg;

  localparam logic [1:0]  OP_DP       = 2'b00;
  localparam logic [1:0]  OP_MEM      = 2'b01;
  localparam logic [1:0]  OP_BR       = 2'b10;
  localparam logic [3:0]  COND_AL     = 4'hE;
  localparam logic [31:0] HALT_WORD   = 32'hEAFFFFFE;
  // Funct[5:4] must read 2'b10 for a branch to be well formed.
  localparam logic [1:0]  BR_FUNCT_HI = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_HALT      = 3'd3,
    ST_DONE      = 3'd4
  } enc_state_t;

  function automatic logic is_illegal(input logic [1:0] op, input logic [5:0] funct);
    return (op == 2'b11) || ((op == OP_BR) && (funct[5:4] != BR_FUNCT_HI));
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instr_pack
// Brief  : Combinational field packer: request fields -> 32-bit ARM word
//          (cond = AL) plus a legality flag.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        illegal
);

  // Pack fields by op class; branches drop rn/rd/src2 and keep only funct[5:4].
  always_comb begin
    illegal = is_illegal(op, funct);
    case (op)
      OP_DP, OP_MEM: word = {COND_AL, op, funct, rn, rd, src2};
      OP_BR:         word = {COND_AL, OP_BR, funct[5:4], imm24};
      default:       word = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : instr_encoder
// Brief  : Accepts field-level instruction requests, encodes them and writes
//          them sequentially into instruction memory, terminating the program
//          with a branch-to-self halt word.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [5:0]        req_funct,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [11:0]       req_src2,
  input  logic [23:0]       req_imm24,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              overflow,
  output logic              err_illegal
);

  localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
  // Top slot is reserved for the halt word.
  localparam logic [ADDR_W-1:0] LAST_SLOT = {ADDR_W{1'b1}};

  enc_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [31:0]       word_q;
  logic              last_q;
  logic [31:0]       pack_word;
  logic              pack_illegal;

  assign ptr_next = ptr + 1'b1;

  // Encode straight from the request bus so the word can be captured at the
  // transfer edge; the bus need only be stable during that cycle.
  instr_pack u_pack (
    .op      (req_op),
    .funct   (req_funct),
    .rn      (req_rn),
    .rd      (req_rd),
    .src2    (req_src2),
    .imm24   (req_imm24),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Sequencer: start rewinds from any state, reset overrides start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE_WAIT;
      ptr         <= BASE_PTR;
      word_q      <= '0;
      last_q      <= 1'b0;
      overflow    <= 1'b0;
      err_illegal <= 1'b0;
    end else if (start) begin
      state       <= ST_IDLE;
      ptr         <= BASE_PTR;
      overflow    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready is high throughout IDLE when start is low.
          if (req_valid) begin
            word_q <= pack_word;
            last_q <= req_last;
            if (pack_illegal) begin
              err_illegal <= 1'b1;
              if (req_last) state <= ST_HALT;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          ptr <= ptr_next;
          if (last_q) begin
            state <= ST_HALT;
          end else if (ptr_next == LAST_SLOT) begin
            overflow <= 1'b1;
            state    <= ST_HALT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: state <= ST_DONE;
        default: state <= state;
      endcase
    end
  end

  // Outputs decode from state; start suppresses the write and the handshake
  // in the cycle it is asserted.
  always_comb begin
    req_ready  = (state == ST_IDLE) && !start;
    imem_we    = ((state == ST_WRITE) || (state == ST_HALT)) && !start;
    imem_addr  = ptr;
    done       = (state == ST_DONE);
    case (state)
      ST_WRITE: imem_wdata = word_q;
      ST_HALT:  imem_wdata = HALT_WORD;
      default:  imem_wdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_instr_encoder
// Brief  : Self-checking bench for instr_encoder (ADDR_W=6 and ADDR_W=2).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic        last;
  } req_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic [31:0] word;
    bit          ill;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v[2];
  logic        start_v[2];
  logic        valid_v[2];
  logic        ready_v[2];
  logic [1:0]  op_v[2];
  logic [5:0]  funct_v[2];
  logic [3:0]  rn_v[2];
  logic [3:0]  rd_v[2];
  logic [11:0] src2_v[2];
  logic [23:0] imm_v[2];
  logic        last_v[2];
  logic        we_v[2];
  logic [5:0]  addr_v[2];
  logic [31:0] wdata_v[2];
  logic        done_v[2];
  logic        ovf_v[2];
  logic        err_v[2];
  logic [5:0]  addr0;
  logic [1:0]  addr1;

  assign addr_v[0] = addr0;
  assign addr_v[1] = {4'b0000, addr1};

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]),
    .req_valid(valid_v[0]), .req_ready(ready_v[0]),
    .req_op(op_v[0]), .req_funct(funct_v[0]), .req_rn(rn_v[0]), .req_rd(rd_v[0]),
    .req_src2(src2_v[0]), .req_imm24(imm_v[0]), .req_last(last_v[0]),
    .imem_we(we_v[0]), .imem_addr(addr0), .imem_wdata(wdata_v[0]),
    .done(done_v[0]), .overflow(ovf_v[0]), .err_illegal(err_v[0])
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]),
    .req_valid(valid_v[1]), .req_ready(ready_v[1]),
    .req_op(op_v[1]), .req_funct(funct_v[1]), .req_rn(rn_v[1]), .req_rd(rd_v[1]),
    .req_src2(src2_v[1]), .req_imm24(imm_v[1]), .req_last(last_v[1]),
    .imem_we(we_v[1]), .imem_addr(addr1), .imem_wdata(wdata_v[1]),
    .done(done_v[1]), .overflow(ovf_v[1]), .err_illegal(err_v[1])
  );

  int checks   = 0;
  int failures = 0;

  wr_t  got0[$];
  wr_t  got1[$];
  req_t prog_q[$];
  wr_t  exp_q[$];
  int   exp_acc;
  bit   exp_ov, exp_er, exp_dn;

  // Capture every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (we_v[0]) begin w.addr = addr_v[0]; w.data = wdata_v[0]; got0.push_back(w); end
    if (we_v[1]) begin w.addr = addr_v[1]; w.data = wdata_v[1]; got1.push_back(w); end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference encoding built from the ARM field layout with plain arithmetic.
  function automatic logic [31:0] ref_word(input req_t r);
    if (r.op == 2'd2)
      return 32'hE000_0000 + (32'd2 << 26) + ({30'd0, r.funct[5:4]} << 24) + {8'd0, r.imm24};
    return 32'hE000_0000 + ({30'd0, r.op} << 26) + ({26'd0, r.funct} << 20) +
           ({28'd0, r.rn} << 16) + ({28'd0, r.rd} << 12) + {20'd0, r.src2};
  endfunction

  function automatic bit ref_illegal(input req_t r);
    return (r.op == 2'd3) || (r.op == 2'd2 && r.funct[5:4] != 2'b10);
  endfunction

  // Program-level model: expected write list, accepted count and flags.
  function automatic void model(input int depth);
    int  ptr = 0;
    bit  stop = 0;
    wr_t w;
    exp_q.delete();
    exp_acc = 0; exp_ov = 0; exp_er = 0; exp_dn = 0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (!stop) begin
        exp_acc++;
        if (ref_illegal(prog_q[i])) begin
          exp_er = 1;
          if (prog_q[i].last) begin
            w.addr = 6'(ptr); w.data = 32'hEAFFFFFE; exp_q.push_back(w);
            exp_dn = 1; stop = 1;
          end
        end else begin
          w.addr = 6'(ptr); w.data = ref_word(prog_q[i]); exp_q.push_back(w);
          ptr++;
          if (prog_q[i].last || ptr == depth - 1) begin
            if (!prog_q[i].last) exp_ov = 1;
            w.addr = 6'(ptr); w.data = 32'hEAFFFFFE; exp_q.push_back(w);
            exp_dn = 1; stop = 1;
          end
        end
      end
    end
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.op    = 2'($urandom_range(0, 3));
    r.funct = 6'($urandom);
    if (r.op == 2'd2 && $urandom_range(0, 3) != 0) r.funct[5:4] = 2'b10;
    r.rn    = 4'($urandom);
    r.rd    = 4'($urandom);
    r.src2  = 12'($urandom);
    r.imm24 = 24'($urandom);
    r.last  = 1'b0;
    return r;
  endfunction

  task automatic scramble(input int k);
    op_v[k] = 2'($urandom); funct_v[k] = 6'($urandom); rn_v[k] = 4'($urandom);
    rd_v[k] = 4'($urandom); src2_v[k] = 12'($urandom); imm_v[k] = 24'($urandom);
    last_v[k] = 1'($urandom);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk); start_v[k] = 1'b1;
    @(posedge clk); #1; start_v[k] = 1'b0;
  endtask

  task automatic pulse_reset(input int k);
    @(negedge clk); rst_v[k] = 1'b1;
    @(posedge clk); #1; rst_v[k] = 1'b0;
  endtask

  task automatic clear_got(input int k);
    if (k == 0) got0.delete(); else got1.delete();
  endtask

  // Present one request and hold it until accepted (bounded); inputs are
  // scrambled right after the transfer edge.
  task automatic drive_req(input int k, input req_t r, output bit ok);
    int waited = 0;
    @(negedge clk);
    op_v[k] = r.op; funct_v[k] = r.funct; rn_v[k] = r.rn; rd_v[k] = r.rd;
    src2_v[k] = r.src2; imm_v[k] = r.imm24; last_v[k] = r.last; valid_v[k] = 1'b1;
    while (!ready_v[k] && waited < 20) begin @(negedge clk); waited++; end
    ok = ready_v[k];
    if (ok) begin @(posedge clk); #1; end
    valid_v[k] = 1'b0;
    scramble(k);
  endtask

  task automatic check_reset_vals(input int k, input string name);
    check({name, "_ready"}, 32'(ready_v[k]), 0);
    check({name, "_we"},    32'(we_v[k]),    0);
    check({name, "_addr"},  32'(addr_v[k]),  0);
    check({name, "_wdata"}, wdata_v[k],      0);
    check({name, "_done"},  32'(done_v[k]),  0);
    check({name, "_ovf"},   32'(ovf_v[k]),   0);
    check({name, "_err"},   32'(err_v[k]),   0);
  endtask

  // Start, stream prog_q, then compare writes and flags with the model.
  task automatic run_program(input int k, input int depth, input string name);
    bit  ok;
    bit  seen_ready;
    int  w;
    wr_t got[$];
    model(depth);
    clear_got(k);
    pulse_start(k);
    for (int i = 0; i < prog_q.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i < exp_acc) begin
        drive_req(k, prog_q[i], ok);
        check({name, "_accept"}, 32'(ok), 1);
        if (!ok) break;
      end else begin
        // Program is over: further requests must never be taken.
        @(negedge clk);
        op_v[k] = prog_q[i].op; valid_v[k] = 1'b1;
        seen_ready = 0;
        repeat (6) begin if (ready_v[k]) seen_ready = 1; @(negedge clk); end
        valid_v[k] = 1'b0;
        check({name, "_no_accept"}, 32'(seen_ready), 0);
        break;
      end
    end
    if (exp_dn) begin
      w = 0;
      while (!done_v[k] && w < 30) begin @(negedge clk); w++; end
    end else begin
      repeat (3) @(negedge clk);
    end
    check({name, "_done"},  32'(done_v[k]),  32'(exp_dn));
    check({name, "_ovf"},   32'(ovf_v[k]),   32'(exp_ov));
    check({name, "_err"},   32'(err_v[k]),   32'(exp_er));
    check({name, "_ready"}, 32'(ready_v[k]), 32'(!exp_dn));
    if (k == 0) got = got0; else got = got1;
    check({name, "_nwr"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", name, i), 32'(got[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_wr%0d_data", name, i), got[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t tbl[8];
    req_t r;
    bit   ok;
    bit   seen_ready;
    int   n, li;

    tbl[0] = '{2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0,      32'hE2821005, 1'b0};
    tbl[1] = '{2'b01, 6'b011001, 4'd0, 4'd3, 12'h008, 24'h0,      32'hE5903008, 1'b0};
    tbl[2] = '{2'b10, 6'b100000, 4'hF, 4'hF, 12'hFFF, 24'h000003, 32'hEA000003, 1'b0};
    tbl[3] = '{2'b11, 6'b000000, 4'd1, 4'd1, 12'h001, 24'h0,      32'h0,        1'b1};
    tbl[4] = '{2'b10, 6'b010000, 4'd0, 4'd0, 12'h000, 24'h000010, 32'h0,        1'b1};
    tbl[5] = '{2'b01, 6'b011000, 4'd5, 4'd4, 12'h0FF, 24'h0,      32'hE58540FF, 1'b0};
    tbl[6] = '{2'b00, 6'b000100, 4'd7, 4'd6, 12'h008, 24'h0,      32'hE0476008, 1'b0};
    tbl[7] = '{2'b10, 6'b101100, 4'd3, 4'd3, 12'h123, 24'h800000, 32'hEA800000, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; start_v[k] = 1'b0; valid_v[k] = 1'b0; scramble(k);
    end
    repeat (2) @(posedge clk);
    #1; rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    @(negedge clk);
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    seen_ready = 0;
    repeat (4) begin if (ready_v[0] || ready_v[1]) seen_ready = 1; @(negedge clk); end
    check("idle_wait_ready", 32'(seen_ready), 0);

    // Encoding table: each vector as a one-instruction program with last set.
    for (int i = 0; i < 8; i++) begin
      prog_q.delete();
      r = '{tbl[i].op, tbl[i].funct, tbl[i].rn, tbl[i].rd, tbl[i].src2, tbl[i].imm24, 1'b1};
      prog_q.push_back(r);
      run_program(0, 64, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_nwr", i), 32'(got0.size()), tbl[i].ill ? 1 : 2);
      check($sformatf("vec%0d_tbl_err", i), 32'(err_v[0]), 32'(tbl[i].ill));
      if (!tbl[i].ill && got0.size() > 0)
        check($sformatf("vec%0d_tbl_word", i), got0[0].data, tbl[i].word);
    end

    // ADD without last: one write, then ready again.
    prog_q.delete();
    prog_q.push_back('{2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0});
    run_program(0, 64, "add_nolast");

    // B +3 followed by an illegal last request.
    prog_q.delete();
    prog_q.push_back('{2'b10, 6'b100000, 4'd0, 4'd0, 12'h0, 24'h000003, 1'b0});
    prog_q.push_back('{2'b11, 6'b000000, 4'd0, 4'd0, 12'h0, 24'h0, 1'b1});
    run_program(0, 64, "b_then_ill");

    // Small memory: five legal requests, none last.
    prog_q.delete();
    for (int i = 0; i < 5; i++)
      prog_q.push_back('{2'b00, 6'b101000, 4'(i), 4'(i + 1), 12'(i), 24'h0, 1'b0});
    run_program(1, 4, "ovf4");
    check("ovf4_flag", 32'(ovf_v[1]), 1);

    // start during WRITE aborts the write and clears flags.
    clear_got(0);
    pulse_start(0);
    drive_req(0, '{2'b11, 6'b0, 4'd0, 4'd0, 12'h0, 24'h0, 1'b0}, ok);
    @(negedge clk);
    check("abort_err_set", 32'(err_v[0]), 1);
    drive_req(0, '{2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0}, ok);
    start_v[0] = 1'b1;
    @(negedge clk);
    check("abort_we", 32'(we_v[0]), 0);
    @(posedge clk); #1; start_v[0] = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready_v[0]), 1);
    check("abort_addr",  32'(addr_v[0]),  0);
    check("abort_err",   32'(err_v[0]),   0);
    check("abort_ovf",   32'(ovf_v[0]),   0);
    check("abort_nwr",   32'(got0.size()), 0);

    // Reset while the halt word is being written.
    pulse_start(0);
    drive_req(0, '{2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1}, ok);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(negedge clk);
    check("rsthalt_in_halt", wdata_v[0], 32'hEAFFFFFE);
    @(posedge clk); #1; rst_v[0] = 1'b0;
    @(negedge clk);
    check_reset_vals(0, "rsthalt");
    seen_ready = 0;
    repeat (3) begin if (ready_v[0]) seen_ready = 1; @(negedge clk); end
    check("rsthalt_ready_low", 32'(seen_ready), 0);

    // Randomized programs on both memory sizes.
    for (int t = 0; t < 60; t++) begin
      prog_q.delete();
      n  = $urandom_range(1, 7);
      li = ($urandom_range(0, 9) < 7) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) begin
        r = rand_req();
        r.last = (i == li);
        prog_q.push_back(r);
      end
      if (t % 2 == 0) run_program(0, 64, $sformatf("rnd%0d", t));
      else            run_program(1, 4,  $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
